// File: rtl/mips_store_buffer.sv
// Posted-write buffer with youngest-entry coalescing and store-to-load forwarding; drain head shows 1 cycle after accept.
// Backpressure: mem_ready holds the head stable; stall to the core only when full.
module mips_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memwrite,
  input  logic [AW-1:0]              dataadr,
  input  logic [DW-1:0]              writedata,
  input  logic [AW-1:0]              loadadr,
  output logic                       stall,
  output logic                       fwd_hit,
  output logic [DW-1:0]              fwd_data,
  output logic                       mem_we,
  output logic [AW-1:0]              mem_adr,
  output logic [DW-1:0]              mem_wd,
  input  logic                       mem_ready,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] adr_q [DEPTH];
  logic [DW-1:0] dat_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0] head_q, tail_q, young;
  logic [CW-1:0] cnt_q;
  logic full, pop, push, coalesce;
  logic [PW-1:0] idx;

  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign stall  = memwrite & full;
  assign count  = cnt_q;
  assign mem_we = ~empty;
  assign mem_adr = adr_q[head_q];
  assign mem_wd  = dat_q[head_q];
  assign pop    = mem_we & mem_ready;
  assign young  = tail_q - PW'(1);

  // A lone entry leaving this edge can't absorb the new store, or the new data would be lost.
  assign coalesce = memwrite & ~stall & ~empty & (adr_q[young] == dataadr)
                  & ~((cnt_q == CW'(1)) & pop);
  assign push     = memwrite & ~stall & ~coalesce;

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (vld_q[idx] && (adr_q[idx] == loadadr)) begin
        fwd_hit  = 1'b1;
        fwd_data = dat_q[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        adr_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PW'(1);
      end
      if (push) begin
        adr_q[tail_q] <= dataadr;
        dat_q[tail_q] <= writedata;
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PW'(1);
      end
      if (coalesce) begin
        dat_q[young] <= writedata;
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_mips_store_buffer.sv
// Directed bench for mips_store_buffer: reset, full/stall, coalescing, forwarding, drain order, reset mid-drain.
module tb_mips_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr, writedata, loadadr;
  logic        stall, fwd_hit, mem_we, mem_ready, empty;
  logic [31:0] fwd_data, mem_adr, mem_wd;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_adr_q[$];
  logic [31:0] exp_dat_q[$];
  logic [15:0] rdy_pat;
  logic [31:0] ea [4];
  logic [31:0] ed [4];
  int          nst;

  mips_store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .loadadr(loadadr), .stall(stall),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .mem_we(mem_we),
    .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_ready(mem_ready),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
  endtask

  initial begin
    reset = 1'b0; memwrite = 1'b1; dataadr = 84; writedata = 7;
    loadadr = 84; mem_ready = 1'b0;

    // T1: held in reset with a store pending
    cyc(); cyc();
    chk("t1_rst_mem_we", mem_we, 0);
    chk("t1_rst_stall", stall, 0);
    chk("t1_rst_count", count, 0);
    chk("t1_rst_fwd_hit", fwd_hit, 0);
    chk("t1_rst_fwd_data", fwd_data, 0);
    chk("t1_rst_empty", empty, 1);
    reset = 1'b1;
    #1;
    chk("t1_same_cycle_no_fwd", fwd_hit, 0);
    cyc();
    memwrite = 1'b0;
    #1;
    chk("t1_mem_we", mem_we, 1);
    chk("t1_mem_adr", mem_adr, 84);
    chk("t1_mem_wd", mem_wd, 7);
    chk("t1_count", count, 1);
    chk("t1_fwd_hit", fwd_hit, 1);
    chk("t1_fwd_data", fwd_data, 7);
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("t1_drained", count, 0);

    // T2: fill to full, then stall and pop/accept
    for (int i = 0; i < 4; i++) begin
      st(80 + 4*i, 100 + i);
      #1;
      chk("t2_fill_stall", stall, 0);
      cyc();
    end
    chk("t2_count_full", count, 4);
    st(96, 104);
    #1;
    chk("t2_stall_full", stall, 1);
    cyc();
    chk("t2_count_held", count, 4);
    chk("t2_stall_held", stall, 1);
    mem_ready = 1'b1;
    #1;
    chk("t2_stall_with_pop", stall, 1);
    chk("t2_head_80", mem_adr, 80);
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("t2_count_after_pop", count, 3);
    chk("t2_stall_released", stall, 0);
    cyc();
    memwrite = 1'b0;
    #1;
    chk("t2_count_refill", count, 4);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_drain_we", mem_we, 1);
      chk("t2_drain_adr", mem_adr, 84 + 4*i);
      chk("t2_drain_wd", mem_wd, 101 + i);
      cyc();
    end
    mem_ready = 1'b0;
    chk("t2_empty", empty, 1);

    // T3: back-to-back same address coalesces
    st(80, 5); cyc();
    st(80, 9); cyc();
    memwrite = 1'b0;
    #1;
    chk("t3_coalesce_count", count, 1);
    chk("t3_coalesce_wd", mem_wd, 9);
    mem_ready = 1'b1; cyc(); mem_ready = 1'b0;
    chk("t3_empty", count, 0);
    st(80, 5); cyc();
    st(84, 1); cyc();
    st(80, 9); cyc();
    memwrite = 1'b0;
    #1;
    chk("t3_no_coalesce_count", count, 3);

    // T4: forwarding, youngest match wins
    loadadr = 80; #1;
    chk("t4_hit80", fwd_hit, 1);
    chk("t4_data80", fwd_data, 9);
    loadadr = 84; #1;
    chk("t4_hit84", fwd_hit, 1);
    chk("t4_data84", fwd_data, 1);
    loadadr = 88; #1;
    chk("t4_hit88", fwd_hit, 0);
    chk("t4_data88", fwd_data, 0);
    ea[0] = 80; ed[0] = 5; ea[1] = 84; ed[1] = 1; ea[2] = 80; ed[2] = 9;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t3_order_adr", mem_adr, ea[i]);
      chk("t3_order_wd", mem_wd, ed[i]);
      cyc();
    end
    mem_ready = 1'b0;
    chk("t3_order_empty", empty, 1);

    // T5: lone entry draining while same address is stored
    st(80, 5); cyc();
    memwrite = 1'b0;
    mem_ready = 1'b1;
    st(80, 6);
    #1;
    chk("t5_first_adr", mem_adr, 80);
    chk("t5_first_wd", mem_wd, 5);
    cyc();
    memwrite = 1'b0;
    #1;
    chk("t5_count", count, 1);
    chk("t5_second_adr", mem_adr, 80);
    chk("t5_second_wd", mem_wd, 6);
    cyc();
    mem_ready = 1'b0;
    chk("t5_empty", empty, 1);

    // T6: fixed ready pattern with scoreboard, then reset mid-drain
    rdy_pat = 16'b1011_0110_1101_0011;
    nst = 0;
    for (int c = 0; c < 48; c++) begin
      memwrite  = (nst < 12);
      dataadr   = 32'h100 + 32'(4*nst);
      writedata = 32'(3*nst + 1);
      mem_ready = rdy_pat[c % 16];
      #1;
      if (mem_we && mem_ready) begin
        if (exp_adr_q.size() == 0) begin
          chk("t6_unexpected_pop", 1, 0);
        end else begin
          chk("t6_sb_adr", mem_adr, exp_adr_q.pop_front());
          chk("t6_sb_wd", mem_wd, exp_dat_q.pop_front());
        end
      end
      if (memwrite && !stall) begin
        exp_adr_q.push_back(dataadr);
        exp_dat_q.push_back(writedata);
        nst++;
      end
      cyc();
    end
    memwrite = 1'b0; mem_ready = 1'b0;
    chk("t6_all_stored", nst, 12);
    chk("t6_sb_drained", exp_adr_q.size(), 0);
    chk("t6_empty", empty, 1);
    st(32'h200, 1); cyc();
    st(32'h204, 2); cyc();
    st(32'h208, 3); cyc();
    memwrite = 1'b0;
    loadadr = 32'h204;
    mem_ready = 1'b1;
    #1;
    chk("t6_pre_rst_we", mem_we, 1);
    chk("t6_pre_rst_adr", mem_adr, 32'h200);
    cyc();
    #2;
    memwrite = 1'b1;
    reset = 1'b0;
    #1;
    chk("t6_rst_we", mem_we, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_fwd", fwd_hit, 0);
    chk("t6_rst_stall", stall, 0);
    cyc();
    chk("t6_rst_hold_we", mem_we, 0);
    memwrite = 1'b0;
    reset = 1'b1;
    cyc();
    chk("t6_post_count", count, 0);
    chk("t6_post_we", mem_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
